voice_mixer: RTL
================

Name: voice_mixer

Overview:
- Downstream neighbour of the DDS phase stage; consumes one 10-bit phase plus voice index per pipeline round.
- Per voice: maps phase to a signed waveform sample by a per-voice shape, scales by a per-voice 8-bit gain and sums across voices.
- At frame end, emits one saturated signed audio sample with a single-cycle valid strobe for the DAC/output stage.
- Shape and gain are programmed from the SPI command path.

Parameters:
- NUM_VOICES, 8, voices per frame; legal range 1..256.
- ACC_WIDTH, 26, signed accumulator width. Must be at least 18+clog2(NUM_VOICES).
- OUT_WIDTH, 16, signed output sample width.
- OUT_SHIFT, 2, arithmetic right shift applied to the frame sum before saturation.

Ports:
- i_clk  in  1  system clock
- i_reset_n  in  1  reset; asynchronous, active-low
- i_pipeline_state  in  2  shared pipeline phase counter (0,1,2)
- i_phase  in  10  phase from DDS stage, stable during state 2
- i_voice_index  in  8  voice index paired with i_phase
- i_SPI_flag  in  1  one-cycle write strobe for voice settings
- i_SPI_voice_index  in  8  target voice of write
- i_SPI_gain  in  8  unsigned gain to store
- i_SPI_shape  in  2  waveform select to store
- o_sample  out  OUT_WIDTH  signed mixed frame sample
- o_sample_valid  out  1  one-cycle pulse when o_sample is updated
- o_clip  out  1  qualified by o_sample_valid; 1 = this sample saturated

Behaviour:
- Reset:
  - Asynchronous clear on i_reset_n low.
  - Cleared state: all pipeline registers, accumulator and frame state; o_sample=0, o_sample_valid=0, o_clip=0.
  - Every voice's gain=0 and shape=0.
  - Reset mid-frame discards the partial sum; no valid pulse follows.
- Capture (edge E):
  - Taken on each rising edge where i_pipeline_state==2 and i_voice_index<NUM_VOICES: register i_phase, i_voice_index, and that voice's gain and shape.
  - Index >= NUM_VOICES: ignored entirely, including any frame-start or frame-end effect.
  - States 0, 1 and 3: no capture.
- Waveform (E+1). Shape maps phase p to a signed 10-bit value s:
  - 0 (saw): s = p - 512.
  - 1 (square): s = +511 if p[9]==0, else -512.
  - 2 (triangle): t = p[9] ? ~p[8:0] : p[8:0]; s = 2t - 512.
  - 3 (silent): s = 0.
  - At the same edge, register product = s * {1'b0,gain}: signed 18-bit, exact, no rounding.
- Accumulate (E+2):
  - Voice index 0: acc <= product, sign-extended. This starts a new frame and discards any prior partial sum, so frames resynchronise.
  - Any other voice: acc <= acc + product.
  - Voice index NUM_VOICES-1 (including NUM_VOICES==1, where it coincides with voice 0): compute f = (this edge's acc result) >>> OUT_SHIFT.
  - o_sample <= f clamped to [-2^(OUT_WIDTH-1), 2^(OUT_WIDTH-1)-1].
  - o_clip <= 1 if clamped, else 0.
  - o_sample_valid <= 1 for exactly one cycle.
  - The accumulator restarts on the next voice 0.
- Latency: o_sample_valid is high in the cycle after edge E+2, where E is the capture edge of the last voice. A new capture may occur every 3 cycles, so the pipeline never stalls.
- o_sample holds its value between pulses. o_clip holds too, but is meaningful only with valid.
- Settings writes:
  - On any edge with i_SPI_flag=1 and i_SPI_voice_index<NUM_VOICES, store gain and shape for that voice. Out-of-range writes are dropped.
  - Write and capture of the same voice on the same edge: the capture takes the old value; the new value applies from the next frame.
  - Writes are independent of i_pipeline_state and need no buffering.

Optional Feature:
- Macro: VOICE_MIXER_CLIP_COUNT_EN.
- Defined: adds input i_clip_clear (1) and output o_clip_count (16), both reset to 0.
  - Counter increments on each o_sample_valid pulse with o_clip=1 and saturates at 16'hFFFF.
  - i_clip_clear=1 zeroes it. Clear wins over a simultaneous increment.
- Undefined: neither port exists and no counter logic is built.

Test Plan (NUM_VOICES=4, defaults otherwise):
- Reset, then run a frame with phases all 0 -> o_sample=0, o_clip=0, exactly one o_sample_valid pulse 3 cycles after voice 3 capture.
- Voice 0 saw gain 255 phase 1023, voices 1-3 gain 0 -> sum 130305, o_sample=32576, o_clip=0.
- All voices square gain 255 phase 0 -> o_sample=32767, o_clip=1. Repeat with phase 512 -> o_sample=-32768, o_clip=1.
- Triangle gain 1, voice 0 only, phases 0/256/511/1023 over four frames -> o_sample = -128/0/127/-128.
- SPI write of voice 2 gain on the same edge as voice 2 capture -> old gain used this frame, new gain next frame. Assert i_reset_n low mid-frame -> outputs 0, no pulse until a full frame after release.
- With VOICE_MIXER_CLIP_COUNT_EN: 3 clipped frames -> o_clip_count=3. i_clip_clear coincident with a clip -> 0.

Source files
------------

// File: rtl/voice_mixer_if.sv
`default_nettype none
//==============================================================================
// Module   : voice_mixer_if
// Brief    : Phase/voice capture, SPI settings write and sample output bundle
//            for voice_mixer.
// Revision : 1.0
//==============================================================================
interface voice_mixer_if #(
    parameter int OUT_WIDTH = 16
) ();
    logic [1:0]           i_pipeline_state;
    logic [9:0]           i_phase;
    logic [7:0]           i_voice_index;
    logic                 i_SPI_flag;
    logic [7:0]           i_SPI_voice_index;
    logic [7:0]           i_SPI_gain;
    logic [1:0]           i_SPI_shape;
    logic [OUT_WIDTH-1:0] o_sample;
    logic                 o_sample_valid;
    logic                 o_clip;

    modport master (
        output i_pipeline_state, i_phase, i_voice_index,
        output i_SPI_flag, i_SPI_voice_index, i_SPI_gain, i_SPI_shape,
        input  o_sample, o_sample_valid, o_clip
    );

    modport slave (
        input  i_pipeline_state, i_phase, i_voice_index,
        input  i_SPI_flag, i_SPI_voice_index, i_SPI_gain, i_SPI_shape,
        output o_sample, o_sample_valid, o_clip
    );
endinterface
`default_nettype wire

// File: rtl/voice_mixer.sv
`default_nettype none
//==============================================================================
// Module   : voice_mixer
// Brief    : Per-voice waveform shaping, gain scaling and frame summation with
//            saturated output. Optional clip counter: VOICE_MIXER_CLIP_COUNT_EN.
// Revision : 1.0
//==============================================================================
module voice_mixer #(
    parameter int NUM_VOICES = 8,
    parameter int ACC_WIDTH  = 26,
    parameter int OUT_WIDTH  = 16,
    parameter int OUT_SHIFT  = 2
) (
    input  wire          i_clk,
    input  wire          i_reset_n,
`ifdef VOICE_MIXER_CLIP_COUNT_EN
    input  wire          i_clip_clear,
    output logic [15:0]  o_clip_count,
`endif
    voice_mixer_if.slave vm
);
    localparam logic [7:0] c_LAST_IDX = 8'(NUM_VOICES - 1);
    localparam logic signed [ACC_WIDTH-1:0] c_OUT_MAX =
        ACC_WIDTH'((64'sd1 <<< (OUT_WIDTH - 1)) - 64'sd1);
    localparam logic signed [ACC_WIDTH-1:0] c_OUT_MIN =
        ACC_WIDTH'(-(64'sd1 <<< (OUT_WIDTH - 1)));

    logic [7:0] r_gain  [NUM_VOICES];
    logic [1:0] r_shape [NUM_VOICES];

    logic w_cap, w_wr;
    logic [7:0] w_gain_rd;
    logic [1:0] w_shape_rd;

    assign w_cap = (vm.i_pipeline_state == 2'd2) &&
                   ({1'b0, vm.i_voice_index} < 9'(NUM_VOICES));
    assign w_wr  = vm.i_SPI_flag &&
                   ({1'b0, vm.i_SPI_voice_index} < 9'(NUM_VOICES));

    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            for (int v = 0; v < NUM_VOICES; v++) begin
                r_gain[v]  <= 8'd0;
                r_shape[v] <= 2'd0;
            end
        end else if (w_wr) begin
            for (int v = 0; v < NUM_VOICES; v++) begin
                if (vm.i_SPI_voice_index == 8'(v)) begin
                    r_gain[v]  <= vm.i_SPI_gain;
                    r_shape[v] <= vm.i_SPI_shape;
                end
            end
        end
    end

    always_comb begin
        w_gain_rd  = 8'd0;
        w_shape_rd = 2'd0;
        for (int v = 0; v < NUM_VOICES; v++) begin
            if (vm.i_voice_index == 8'(v)) begin
                w_gain_rd  = r_gain[v];
                w_shape_rd = r_shape[v];
            end
        end
    end

    // Stage 1: capture; settings read here see the pre-write value on a same-edge write
    logic       r_s1_valid, r_s1_first, r_s1_last;
    logic [9:0] r_s1_phase;
    logic [7:0] r_s1_gain;
    logic [1:0] r_s1_shape;

    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            r_s1_valid <= 1'b0;
            r_s1_first <= 1'b0;
            r_s1_last  <= 1'b0;
            r_s1_phase <= 10'd0;
            r_s1_gain  <= 8'd0;
            r_s1_shape <= 2'd0;
        end else begin
            r_s1_valid <= w_cap;
            if (w_cap) begin
                r_s1_first <= (vm.i_voice_index == 8'd0);
                r_s1_last  <= (vm.i_voice_index == c_LAST_IDX);
                r_s1_phase <= vm.i_phase;
                r_s1_gain  <= w_gain_rd;
                r_s1_shape <= w_shape_rd;
            end
        end
    end

    logic [9:0]         w_wave;
    logic [8:0]         w_tri;
    logic signed [17:0] w_prod;

    always_comb begin
        w_tri  = r_s1_phase[9] ? ~r_s1_phase[8:0] : r_s1_phase[8:0];
        w_wave = 10'd0;
        case (r_s1_shape)
            2'd0:    w_wave = {~r_s1_phase[9], r_s1_phase[8:0]};
            2'd1:    w_wave = r_s1_phase[9] ? 10'h200 : 10'h1FF;
            2'd2:    w_wave = {~w_tri[8], w_tri[7:0], 1'b0};
            default: w_wave = 10'd0;
        endcase
        w_prod = $signed({{8{w_wave[9]}}, w_wave}) * $signed({10'd0, r_s1_gain});
    end

    logic                        r_s2_valid, r_s2_first, r_s2_last;
    logic signed [17:0]          r_s2_prod;

    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            r_s2_valid <= 1'b0;
            r_s2_first <= 1'b0;
            r_s2_last  <= 1'b0;
            r_s2_prod  <= 18'sd0;
        end else begin
            r_s2_valid <= r_s1_valid;
            r_s2_first <= r_s1_first;
            r_s2_last  <= r_s1_last;
            r_s2_prod  <= w_prod;
        end
    end

    // Frame-open flag suppresses a pulse for a frame tail whose voice 0 was lost to reset
    logic signed [ACC_WIDTH-1:0] r_acc, w_acc_next, w_frame;
    logic                        r_frame_open, w_emit, w_hi, w_lo;
    logic [OUT_WIDTH-1:0]        r_sample;
    logic                        r_sample_valid, r_clip;

    always_comb begin
        w_acc_next = r_s2_first ? ACC_WIDTH'(r_s2_prod) : r_acc + ACC_WIDTH'(r_s2_prod);
        w_frame    = w_acc_next >>> OUT_SHIFT;
        w_hi       = (w_frame > c_OUT_MAX);
        w_lo       = (w_frame < c_OUT_MIN);
        w_emit     = r_s2_valid && r_s2_last && (r_s2_first || r_frame_open);
    end

    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            r_acc          <= '0;
            r_frame_open   <= 1'b0;
            r_sample       <= '0;
            r_sample_valid <= 1'b0;
            r_clip         <= 1'b0;
        end else begin
            r_sample_valid <= w_emit;
            if (r_s2_valid) begin
                r_acc        <= w_acc_next;
                r_frame_open <= r_s2_last ? 1'b0 : (r_s2_first ? 1'b1 : r_frame_open);
            end
            if (w_emit) begin
                r_clip <= w_hi | w_lo;
                if (w_hi)      r_sample <= c_OUT_MAX[OUT_WIDTH-1:0];
                else if (w_lo) r_sample <= c_OUT_MIN[OUT_WIDTH-1:0];
                else           r_sample <= w_frame[OUT_WIDTH-1:0];
            end
        end
    end

    assign vm.o_sample       = r_sample;
    assign vm.o_sample_valid = r_sample_valid;
    assign vm.o_clip         = r_clip;

`ifdef VOICE_MIXER_CLIP_COUNT_EN
    logic [15:0] r_clip_count;

    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            r_clip_count <= 16'd0;
        end else if (i_clip_clear) begin
            r_clip_count <= 16'd0;
        end else if (r_sample_valid && r_clip && (r_clip_count != 16'hFFFF)) begin
            r_clip_count <= r_clip_count + 16'd1;
        end
    end

    assign o_clip_count = r_clip_count;
`endif
endmodule
`default_nettype wire
